wshb_sdram_arbiter: RTL and testbench
=====================================

Name: wshb_sdram_arbiter

Overview:
Two-master Wishbone arbiter that shares the single SDRAM slave port between the VGA frame reader and the mire/stream writer.
- Sits between the `wshb_if_vga` / `wshb_if_stream` masters and `wshb_if_sdram`, all on `sys_clk`.
- VGA has priority on a tie.
- Per-master beat quantums bound how long either master can hold the bus while the other waits, so neither the VGA FIFO nor the mire is starved.

Parameters:
- QUANTUM_VGA, 64, max acknowledged beats the VGA master keeps the bus while the mire requests.
- QUANTUM_MIRE, 16, max acknowledged beats the mire master keeps the bus while the VGA requests.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset, synchronous to sys_clk, active-high.
- wshb_ifs_vga  wshb_if.slave  DATA_BYTES=4  port facing the VGA reader master.
- wshb_ifs_mire  wshb_if.slave  DATA_BYTES=4  port facing the mire/stream master.
- wshb_ifm_sdram  wshb_if.master  DATA_BYTES=4  port to the SDRAM controller slave.
- gnt_vga  out  1  registered, 1 while VGA owns the bus.
- gnt_mire  out  1  registered, 1 while mire owns the bus.

Behaviour:
- Protocol: classic Wishbone with cti/bte passthrough. A beat terminates on ack, err or rty from the SDRAM slave. No transaction is outstanding after a terminating cycle.
- States: IDLE, GNT_VGA, GNT_MIRE. State is registered; gnt_vga = (state==GNT_VGA), gnt_mire = (state==GNT_MIRE).
- Reset: state=IDLE, beat counter=0, gnt_*=0. In the same cycle, SDRAM cyc/stb=0 and all master ack/err/rty=0.
- IDLE:
  - SDRAM cyc=stb=0.
  - If vga.cyc=1, go to GNT_VGA; else if mire.cyc=1, go to GNT_MIRE; else stay.
  - Tie goes to VGA.
- Grant latency: a request first visible in IDLE at cycle n is forwarded to SDRAM from cycle n+1. Every ownership change inserts at least one IDLE cycle with SDRAM cyc=0.
- GNT_x forwarding (combinational from granted master):
  - To SDRAM: cyc, stb, we, adr, dat_ms, sel, cti, bte.
  - Back to the granted master: ack, err, rty.
  - dat_sm is broadcast to both masters.
  - The non-granted master sees ack=err=rty=0 and may hold stb high indefinitely.
- Beat counter: width $clog2(max(QUANTUM_VGA,QUANTUM_MIRE)+1). It increments on every terminating beat in GNT_x and clears on entering IDLE.
- Leaving GNT_x (next state IDLE) happens when either:
  - the granted master's cyc=0; or
  - a terminating beat occurs with counter==QUANTUM_x-1 and the other master's cyc=1 (quantum expiry).
- Quantum reached with the other master idle: the counter clears to 0 and the grant is kept.
- Preemption: a master preempted mid-burst keeps cyc/stb asserted unacknowledged. It is re-granted later and resumes at its current adr. The SDRAM slave sees a new cycle, since cyc dropped.
- Fairness after preemption: from IDLE following a quantum expiry of master x, the other master wins even if both request. This overrides the VGA tie priority for exactly that decision.
- Simultaneous events: if the granted master drops cyc on the same cycle the quantum expires, the result is the same, IDLE next cycle.
- A stb with cyc=0 is ignored.
- Reset mid-transfer:
  - Next cycle, SDRAM cyc=0 and state=IDLE.
  - An in-flight beat is lost, with no ack to the master.

Decomposition:
- Package wshb_arb_pkg holds:
  - the typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_MIRE} arb_state_t;
  - the localparam function for the counter width.
- Sub-module wshb_mux2: purely combinational steering of master/slave signals from a 2-bit one-hot grant. The FSM and counter stay in the top.

Test Plan:
- Reset: assert sys_rst 3 cycles with both masters' cyc=1 → gnt_*=0, SDRAM cyc=0, no acks; the cycle after release: IDLE→GNT_VGA, gnt_vga=1.
- Lone mire: mire writes 8 beats to adr 0x100..0x11C, slave acks every cycle → gnt_mire from cycle n+1; SDRAM sees all 8 in order with matching dat_ms; counter never forces release.
- Tie: both cyc rise in the same cycle → VGA granted first; mire ack=0 until VGA drops cyc, then 1 IDLE cycle, then gnt_mire.
- VGA quantum: VGA bursts 200 beats, mire requesting throughout, QUANTUM_VGA=64 → handover after the 64th ack, 1 IDLE cycle, then mire granted despite VGA still requesting.
- Mire preemption/resume: mire quantum 16 expires at adr 0x40 with VGA waiting → VGA served; the mire is then re-granted and its next SDRAM beat has adr 0x40; no beat is duplicated or lost.
- Reset mid-burst: sys_rst pulsed during a GNT_MIRE beat with stb=1 → SDRAM cyc=0 next cycle, mire receives no ack, gnt_mire=0.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and sizing helpers for the two-master Wishbone SDRAM arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_MIRE = 2'd2
    } arb_state_t;

    localparam int WB_DATA_BYTES = 4;
    localparam int WB_DW         = 8 * WB_DATA_BYTES;
    localparam int WB_AW         = 32;

    // Beat counter must hold values up to the larger quantum.
    function automatic int cnt_width(input int qa, input int qb);
        int qmax;
        qmax = (qa > qb) ? qa : qb;
        return $clog2(qmax + 1);
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle with cti/bte, shared by masters and the SDRAM slave.
interface wshb_if #(parameter int DATA_BYTES = 4);

    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_mux2.sv
// Combinational steering between two Wishbone masters and one slave,
// selected by a one-hot grant (2'b01 = VGA, 2'b10 = mire, else nobody).
module wshb_mux2
    import wshb_arb_pkg::*;
(
    input  logic [1:0]          gnt,
    input  logic                vga_cyc,
    input  logic                vga_stb,
    input  logic                vga_we,
    input  logic [WB_AW-1:0]    vga_adr,
    input  logic [WB_DW-1:0]    vga_dat_ms,
    input  logic [WB_DATA_BYTES-1:0] vga_sel,
    input  logic [2:0]          vga_cti,
    input  logic [1:0]          vga_bte,
    input  logic                mire_cyc,
    input  logic                mire_stb,
    input  logic                mire_we,
    input  logic [WB_AW-1:0]    mire_adr,
    input  logic [WB_DW-1:0]    mire_dat_ms,
    input  logic [WB_DATA_BYTES-1:0] mire_sel,
    input  logic [2:0]          mire_cti,
    input  logic [1:0]          mire_bte,
    input  logic [WB_DW-1:0]    sdram_dat_sm,
    input  logic                sdram_ack,
    input  logic                sdram_err,
    input  logic                sdram_rty,
    output logic                sdram_cyc,
    output logic                sdram_stb,
    output logic                sdram_we,
    output logic [WB_AW-1:0]    sdram_adr,
    output logic [WB_DW-1:0]    sdram_dat_ms,
    output logic [WB_DATA_BYTES-1:0] sdram_sel,
    output logic [2:0]          sdram_cti,
    output logic [1:0]          sdram_bte,
    output logic [WB_DW-1:0]    vga_dat_sm,
    output logic                vga_ack,
    output logic                vga_err,
    output logic                vga_rty,
    output logic [WB_DW-1:0]    mire_dat_sm,
    output logic                mire_ack,
    output logic                mire_err,
    output logic                mire_rty
);

    // Read data is broadcast; only the granted master ever sees a termination.
    assign vga_dat_sm  = sdram_dat_sm;
    assign mire_dat_sm = sdram_dat_sm;

    // Route request fields to the slave and terminations back to the owner.
    always_comb begin
        sdram_cyc    = 1'b0;
        sdram_stb    = 1'b0;
        sdram_we     = 1'b0;
        sdram_adr    = {WB_AW{1'b0}};
        sdram_dat_ms = {WB_DW{1'b0}};
        sdram_sel    = {WB_DATA_BYTES{1'b0}};
        sdram_cti    = 3'b000;
        sdram_bte    = 2'b00;
        vga_ack      = 1'b0;
        vga_err      = 1'b0;
        vga_rty      = 1'b0;
        mire_ack     = 1'b0;
        mire_err     = 1'b0;
        mire_rty     = 1'b0;
        case (gnt)
            2'b01: begin
                sdram_cyc    = vga_cyc;
                sdram_stb    = vga_stb & vga_cyc;
                sdram_we     = vga_we;
                sdram_adr    = vga_adr;
                sdram_dat_ms = vga_dat_ms;
                sdram_sel    = vga_sel;
                sdram_cti    = vga_cti;
                sdram_bte    = vga_bte;
                vga_ack      = sdram_ack;
                vga_err      = sdram_err;
                vga_rty      = sdram_rty;
            end
            2'b10: begin
                sdram_cyc    = mire_cyc;
                sdram_stb    = mire_stb & mire_cyc;
                sdram_we     = mire_we;
                sdram_adr    = mire_adr;
                sdram_dat_ms = mire_dat_ms;
                sdram_sel    = mire_sel;
                sdram_cti    = mire_cti;
                sdram_bte    = mire_bte;
                mire_ack     = sdram_ack;
                mire_err     = sdram_err;
                mire_rty     = sdram_rty;
            end
            default: begin
                sdram_cyc    = 1'b0;
                sdram_stb    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone arbiter sharing the SDRAM port between the VGA reader
// and the mire writer, with per-master beat quantums to bound waiting time.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int QUANTUM_VGA  = 64,
    parameter int QUANTUM_MIRE = 16
)(
    input  logic    sys_clk,
    input  logic    sys_rst,
    wshb_if.slave   wshb_ifs_vga,
    wshb_if.slave   wshb_ifs_mire,
    wshb_if.master  wshb_ifm_sdram,
    output logic    gnt_vga,
    output logic    gnt_mire
);

    localparam int CNT_W = cnt_width(QUANTUM_VGA, QUANTUM_MIRE);
    localparam logic [CNT_W-1:0] LAST_VGA  = CNT_W'(QUANTUM_VGA - 1);
    localparam logic [CNT_W-1:0] LAST_MIRE = CNT_W'(QUANTUM_MIRE - 1);

    arb_state_t         state_r;
    arb_state_t         state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               pref_mire_r;
    logic               pref_mire_s;
    logic               gnt_vga_r;
    logic               gnt_mire_r;
    logic [1:0]         sel_s;
    logic               term_s;

    logic               sdram_cyc_s;
    logic               sdram_stb_s;
    logic               sdram_we_s;
    logic [WB_AW-1:0]   sdram_adr_s;
    logic [WB_DW-1:0]   sdram_dat_ms_s;
    logic [WB_DATA_BYTES-1:0] sdram_sel_s;
    logic [2:0]         sdram_cti_s;
    logic [1:0]         sdram_bte_s;
    logic [WB_DW-1:0]   vga_dat_sm_s;
    logic               vga_ack_s;
    logic               vga_err_s;
    logic               vga_rty_s;
    logic [WB_DW-1:0]   mire_dat_sm_s;
    logic               mire_ack_s;
    logic               mire_err_s;
    logic               mire_rty_s;

    // Steering select; reset masks the bus in the very cycle it is asserted.
    always_comb begin
        sel_s = 2'b00;
        if (sys_rst) begin
            sel_s = 2'b00;
        end else begin
            case (state_r)
                GNT_VGA:  sel_s = 2'b01;
                GNT_MIRE: sel_s = 2'b10;
                default:  sel_s = 2'b00;
            endcase
        end
    end

    wshb_mux2 u_mux (
        .gnt          (sel_s),
        .vga_cyc      (wshb_ifs_vga.cyc),
        .vga_stb      (wshb_ifs_vga.stb),
        .vga_we       (wshb_ifs_vga.we),
        .vga_adr      (wshb_ifs_vga.adr),
        .vga_dat_ms   (wshb_ifs_vga.dat_ms),
        .vga_sel      (wshb_ifs_vga.sel),
        .vga_cti      (wshb_ifs_vga.cti),
        .vga_bte      (wshb_ifs_vga.bte),
        .mire_cyc     (wshb_ifs_mire.cyc),
        .mire_stb     (wshb_ifs_mire.stb),
        .mire_we      (wshb_ifs_mire.we),
        .mire_adr     (wshb_ifs_mire.adr),
        .mire_dat_ms  (wshb_ifs_mire.dat_ms),
        .mire_sel     (wshb_ifs_mire.sel),
        .mire_cti     (wshb_ifs_mire.cti),
        .mire_bte     (wshb_ifs_mire.bte),
        .sdram_dat_sm (wshb_ifm_sdram.dat_sm),
        .sdram_ack    (wshb_ifm_sdram.ack),
        .sdram_err    (wshb_ifm_sdram.err),
        .sdram_rty    (wshb_ifm_sdram.rty),
        .sdram_cyc    (sdram_cyc_s),
        .sdram_stb    (sdram_stb_s),
        .sdram_we     (sdram_we_s),
        .sdram_adr    (sdram_adr_s),
        .sdram_dat_ms (sdram_dat_ms_s),
        .sdram_sel    (sdram_sel_s),
        .sdram_cti    (sdram_cti_s),
        .sdram_bte    (sdram_bte_s),
        .vga_dat_sm   (vga_dat_sm_s),
        .vga_ack      (vga_ack_s),
        .vga_err      (vga_err_s),
        .vga_rty      (vga_rty_s),
        .mire_dat_sm  (mire_dat_sm_s),
        .mire_ack     (mire_ack_s),
        .mire_err     (mire_err_s),
        .mire_rty     (mire_rty_s)
    );

    assign wshb_ifm_sdram.cyc    = sdram_cyc_s;
    assign wshb_ifm_sdram.stb    = sdram_stb_s;
    assign wshb_ifm_sdram.we     = sdram_we_s;
    assign wshb_ifm_sdram.adr    = sdram_adr_s;
    assign wshb_ifm_sdram.dat_ms = sdram_dat_ms_s;
    assign wshb_ifm_sdram.sel    = sdram_sel_s;
    assign wshb_ifm_sdram.cti    = sdram_cti_s;
    assign wshb_ifm_sdram.bte    = sdram_bte_s;
    assign wshb_ifs_vga.dat_sm   = vga_dat_sm_s;
    assign wshb_ifs_vga.ack      = vga_ack_s;
    assign wshb_ifs_vga.err      = vga_err_s;
    assign wshb_ifs_vga.rty      = vga_rty_s;
    assign wshb_ifs_mire.dat_sm  = mire_dat_sm_s;
    assign wshb_ifs_mire.ack     = mire_ack_s;
    assign wshb_ifs_mire.err     = mire_err_s;
    assign wshb_ifs_mire.rty     = mire_rty_s;

    // A forwarded beat ends on any of ack/err/rty.
    assign term_s = sdram_cyc_s & sdram_stb_s &
                    (wshb_ifm_sdram.ack | wshb_ifm_sdram.err | wshb_ifm_sdram.rty);

    // Next-state, beat counter and post-preemption preference.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pref_mire_s = pref_mire_r;
        case (state_r)
            IDLE: begin
                cnt_s       = {CNT_W{1'b0}};
                pref_mire_s = 1'b0;
                if (pref_mire_r && wshb_ifs_mire.cyc) begin
                    state_s = GNT_MIRE;
                end else if (wshb_ifs_vga.cyc) begin
                    state_s = GNT_VGA;
                end else if (wshb_ifs_mire.cyc) begin
                    state_s = GNT_MIRE;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT_VGA: begin
                if (!wshb_ifs_vga.cyc) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (term_s) begin
                    if (cnt_r == LAST_VGA) begin
                        cnt_s = {CNT_W{1'b0}};
                        if (wshb_ifs_mire.cyc) begin
                            state_s     = IDLE;
                            pref_mire_s = 1'b1;
                        end else begin
                            state_s = GNT_VGA;
                        end
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GNT_MIRE: begin
                // VGA already wins ties, so a mire expiry needs no preference flag.
                if (!wshb_ifs_mire.cyc) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (term_s) begin
                    if (cnt_r == LAST_MIRE) begin
                        cnt_s = {CNT_W{1'b0}};
                        if (wshb_ifs_vga.cyc) begin
                            state_s = IDLE;
                        end else begin
                            state_s = GNT_MIRE;
                        end
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s     = IDLE;
                cnt_s       = {CNT_W{1'b0}};
                pref_mire_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered grant flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            pref_mire_r <= 1'b0;
            gnt_vga_r   <= 1'b0;
            gnt_mire_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pref_mire_r <= pref_mire_s;
            gnt_vga_r   <= (state_s == GNT_VGA);
            gnt_mire_r  <= (state_s == GNT_MIRE);
        end
    end

    assign gnt_vga  = gnt_vga_r;
    assign gnt_mire = gnt_mire_r;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Directed bench for the two-master SDRAM arbiter with behavioural masters and an always-ack slave.
module tb_wshb_sdram_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic gnt_vga;
    logic gnt_mire;

    always #5 sys_clk = ~sys_clk;

    wshb_if #(.DATA_BYTES(4)) vga_if ();
    wshb_if #(.DATA_BYTES(4)) mire_if ();
    wshb_if #(.DATA_BYTES(4)) sdram_if ();

    wshb_sdram_arbiter #(.QUANTUM_VGA(64), .QUANTUM_MIRE(16)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .wshb_ifs_vga   (vga_if.slave),
        .wshb_ifs_mire  (mire_if.slave),
        .wshb_ifm_sdram (sdram_if.master),
        .gnt_vga        (gnt_vga),
        .gnt_mire       (gnt_mire)
    );

    // Zero-wait-state slave; read data is the inverted address.
    assign sdram_if.ack    = sdram_if.cyc & sdram_if.stb;
    assign sdram_if.err    = 1'b0;
    assign sdram_if.rty    = 1'b0;
    assign sdram_if.dat_sm = ~sdram_if.adr;

    int checks = 0;
    int passes = 0;

    logic        rst_req = 1'b1;
    logic        v_cyc = 1'b0, m_cyc = 1'b0;
    logic [31:0] v_adr = 32'h0, m_adr = 32'h0;
    int          v_left = 0, m_left = 0;
    int          v_acks = 0, m_acks = 0;

    int          log_n = 0;
    logic [31:0] log_adr [0:511];
    logic [31:0] log_dat [0:511];
    logic        log_we  [0:511];
    int          log_src [0:511];

    task automatic step();
        @(negedge sys_clk);
        sys_rst        = rst_req;
        vga_if.cyc     = v_cyc;
        vga_if.stb     = v_cyc;
        vga_if.we      = 1'b0;
        vga_if.adr     = v_adr;
        vga_if.dat_ms  = 32'h0000_0000;
        vga_if.sel     = 4'hF;
        vga_if.cti     = 3'b000;
        vga_if.bte     = 2'b00;
        mire_if.cyc    = m_cyc;
        mire_if.stb    = m_cyc;
        mire_if.we     = 1'b1;
        mire_if.adr    = m_adr;
        mire_if.dat_ms = m_adr ^ 32'hA5A5_0000;
        mire_if.sel    = 4'hF;
        mire_if.cti    = 3'b000;
        mire_if.bte    = 2'b00;
        #1;
        if (sdram_if.cyc === 1'b1 && sdram_if.stb === 1'b1 && sdram_if.ack === 1'b1 && log_n < 512) begin
            log_adr[log_n] = sdram_if.adr;
            log_dat[log_n] = sdram_if.dat_ms;
            log_we[log_n]  = sdram_if.we;
            log_src[log_n] = (gnt_vga === 1'b1) ? 1 : ((gnt_mire === 1'b1) ? 2 : 0);
            log_n++;
        end
        if (vga_if.ack === 1'b1) begin
            v_acks++;
            v_adr  = v_adr + 32'd4;
            v_left--;
            if (v_left == 0) v_cyc = 1'b0;
        end
        if (mire_if.ack === 1'b1) begin
            m_acks++;
            m_adr  = m_adr + 32'd4;
            m_left--;
            if (m_left == 0) m_cyc = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        v_cyc = 1'b0;
        m_cyc = 1'b0;
        step();
        rst_req = 1'b0;
        step();
        log_n = 0;
        v_acks = 0;
        m_acks = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset();
        v_cyc = 1'b1; v_left = 1000; v_adr = 32'h0;
        m_cyc = 1'b1; m_left = 1000; m_adr = 32'h0;
        rst_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (gnt_vga !== 1'b0) $display("FAIL reset_gnt_vga: got %b expected 0", gnt_vga); else passes++;
            checks++; if (gnt_mire !== 1'b0) $display("FAIL reset_gnt_mire: got %b expected 0", gnt_mire); else passes++;
            checks++; if (sdram_if.cyc !== 1'b0) $display("FAIL reset_sdram_cyc: got %b expected 0", sdram_if.cyc); else passes++;
            checks++; if ({vga_if.ack, mire_if.ack} !== 2'b00) $display("FAIL reset_acks: got %b expected 00", {vga_if.ack, mire_if.ack}); else passes++;
        end
        rst_req = 1'b0;
        step();
        checks++; if (gnt_vga !== 1'b0 || sdram_if.cyc !== 1'b0) $display("FAIL release_idle: gnt_vga=%b cyc=%b expected 0/0", gnt_vga, sdram_if.cyc); else passes++;
        step();
        checks++; if (gnt_vga !== 1'b1 || gnt_mire !== 1'b0) $display("FAIL release_gnt_vga: got %b%b expected 10", gnt_vga, gnt_mire); else passes++;
        checks++; if (sdram_if.cyc !== 1'b1) $display("FAIL release_sdram_cyc: got %b expected 1", sdram_if.cyc); else passes++;
    endtask

    task automatic test_lone_mire();
        int n;
        logic [31:0] exp_sm;
        do_reset();
        m_cyc = 1'b1; m_adr = 32'h100; m_left = 8;
        step();
        checks++; if (gnt_mire !== 1'b0 || sdram_if.cyc !== 1'b0) $display("FAIL mire_latency_idle: gnt=%b cyc=%b expected 0/0", gnt_mire, sdram_if.cyc); else passes++;
        step();
        checks++; if (gnt_mire !== 1'b1 || sdram_if.adr !== 32'h100) $display("FAIL mire_first_beat: gnt=%b adr=%h expected 1/00000100", gnt_mire, sdram_if.adr); else passes++;
        exp_sm = ~32'h0000_0100;
        checks++; if (vga_if.dat_sm !== exp_sm || mire_if.dat_sm !== exp_sm) $display("FAIL dat_sm_broadcast: vga=%h mire=%h expected %h", vga_if.dat_sm, mire_if.dat_sm, exp_sm); else passes++;
        n = 0;
        while (m_cyc && n < 20) begin step(); n++; end
        chk("mire_burst_cycles", 32'(n), 32'd7);
        chk("mire_beat_count", 32'(log_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_adr[i] !== 32'h100 + 32'(4 * i) || log_dat[i] !== ((32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000) || log_we[i] !== 1'b1 || log_src[i] != 2)
                $display("FAIL mire_beat_%0d: adr=%h dat=%h we=%b src=%0d expected adr=%h", i, log_adr[i], log_dat[i], log_we[i], log_src[i], 32'h100 + 32'(4 * i));
            else passes++;
        end
    endtask

    task automatic test_tie();
        int n;
        logic bad_ack;
        do_reset();
        v_cyc = 1'b1; v_adr = 32'h2000; v_left = 4;
        m_cyc = 1'b1; m_adr = 32'h3000; m_left = 2;
        step();
        step();
        checks++; if (gnt_vga !== 1'b1 || gnt_mire !== 1'b0) $display("FAIL tie_vga_first: got %b%b expected 10", gnt_vga, gnt_mire); else passes++;
        bad_ack = (mire_if.ack !== 1'b0);
        n = 0;
        while (v_cyc && n < 20) begin
            step(); n++;
            if (mire_if.ack !== 1'b0) bad_ack = 1'b1;
        end
        chk("tie_mire_no_ack", 32'(bad_ack), 32'd0);
        step();
        checks++; if (gnt_mire !== 1'b0 || sdram_if.cyc !== 1'b0) $display("FAIL tie_vga_drop: gnt_mire=%b cyc=%b expected 0/0", gnt_mire, sdram_if.cyc); else passes++;
        step();
        checks++; if ({gnt_vga, gnt_mire, sdram_if.cyc} !== 3'b000) $display("FAIL tie_idle_gap: got %b expected 000", {gnt_vga, gnt_mire, sdram_if.cyc}); else passes++;
        step();
        checks++; if (gnt_mire !== 1'b1 || sdram_if.adr !== 32'h3000) $display("FAIL tie_mire_grant: gnt=%b adr=%h expected 1/00003000", gnt_mire, sdram_if.adr); else passes++;
        n = 0;
        while (m_cyc && n < 10) begin step(); n++; end
        checks++;
        if (log_n != 6 || log_src[3] != 1 || log_src[4] != 2 || log_adr[3] !== 32'h200C || log_adr[5] !== 32'h3004)
            $display("FAIL tie_order: n=%0d src3=%0d src4=%0d adr3=%h adr5=%h expected 6/1/2/0000200c/00003004", log_n, log_src[3], log_src[4], log_adr[3], log_adr[5]);
        else passes++;
    endtask

    task automatic test_vga_quantum();
        int n, gaps, vn;
        logic prev_idle, bad_seq;
        do_reset();
        v_cyc = 1'b1; v_adr = 32'h0; v_left = 200;
        m_cyc = 1'b1; m_adr = 32'h8000; m_left = 4;
        prev_idle = 1'b0;
        step();
        n = 0;
        while (n < 100) begin
            step(); n++;
            if (gnt_mire === 1'b1) break;
            prev_idle = (gnt_vga === 1'b0 && sdram_if.cyc === 1'b0);
        end
        chk("vq_acks_before_handover", 32'(v_acks), 32'd64);
        chk("vq_idle_before_mire", 32'(prev_idle), 32'd1);
        checks++; if (v_cyc !== 1'b1 || sdram_if.adr !== 32'h8000) $display("FAIL vq_mire_despite_vga: vcyc=%b adr=%h expected 1/00008000", v_cyc, sdram_if.adr); else passes++;
        n = 0;
        while (m_cyc && n < 10) begin step(); n++; end
        n = 0;
        while (gnt_vga !== 1'b1 && n < 10) begin step(); n++; end
        chk("vq_vga_resume_adr", sdram_if.adr, 32'h100);
        gaps = 0; n = 0;
        while (v_cyc && n < 400) begin
            step(); n++;
            if (v_cyc && gnt_vga !== 1'b1) gaps++;
        end
        chk("vq_no_release_when_alone", 32'(gaps), 32'd0);
        chk("vq_total_acks", 32'(v_acks), 32'd200);
        vn = 0; bad_seq = 1'b0;
        for (int i = 0; i < log_n; i++) begin
            if (log_src[i] == 1) begin
                if (log_adr[i] !== 32'(4 * vn)) bad_seq = 1'b1;
                vn++;
            end
        end
        checks++; if (bad_seq || vn != 200) $display("FAIL vq_sequence: bad=%b beats=%0d expected 0/200", bad_seq, vn); else passes++;
    endtask

    task automatic test_mire_preempt();
        int n, mn;
        logic bad_seq;
        do_reset();
        m_cyc = 1'b1; m_adr = 32'h0; m_left = 40;
        step();
        for (int i = 0; i < 5; i++) step();
        v_cyc = 1'b1; v_adr = 32'h9000; v_left = 3;
        n = 0;
        while (gnt_vga !== 1'b1 && n < 40) begin step(); n++; end
        chk("mp_acks_at_preempt", 32'(m_acks), 32'd16);
        chk("mp_mire_held_adr", m_adr, 32'h40);
        checks++; if (sdram_if.adr !== 32'h9000 || mire_if.ack !== 1'b0) $display("FAIL mp_vga_served: adr=%h mire_ack=%b expected 00009000/0", sdram_if.adr, mire_if.ack); else passes++;
        n = 0;
        while (v_cyc && n < 20) begin step(); n++; end
        n = 0;
        while (gnt_mire !== 1'b1 && n < 10) begin step(); n++; end
        chk("mp_resume_adr", sdram_if.adr, 32'h40);
        n = 0;
        while (m_cyc && n < 100) begin step(); n++; end
        chk("mp_total_acks", 32'(m_acks), 32'd40);
        mn = 0; bad_seq = 1'b0;
        for (int i = 0; i < log_n; i++) begin
            if (log_src[i] == 2) begin
                if (log_adr[i] !== 32'(4 * mn)) bad_seq = 1'b1;
                mn++;
            end
        end
        checks++; if (bad_seq || mn != 40 || v_acks != 3) $display("FAIL mp_sequence: bad=%b mire=%0d vga=%0d expected 0/40/3", bad_seq, mn, v_acks); else passes++;
    endtask

    task automatic test_reset_mid();
        int saved;
        do_reset();
        m_cyc = 1'b1; m_adr = 32'h500; m_left = 10;
        step(); step(); step();
        checks++; if (gnt_mire !== 1'b1 || sdram_if.stb !== 1'b1) $display("FAIL rm_in_burst: gnt=%b stb=%b expected 1/1", gnt_mire, sdram_if.stb); else passes++;
        saved = m_acks;
        rst_req = 1'b1;
        step();
        checks++; if (sdram_if.cyc !== 1'b0 || mire_if.ack !== 1'b0) $display("FAIL rm_rst_cycle: cyc=%b ack=%b expected 0/0", sdram_if.cyc, mire_if.ack); else passes++;
        rst_req = 1'b0;
        step();
        checks++; if ({gnt_mire, sdram_if.cyc, mire_if.ack} !== 3'b000) $display("FAIL rm_after_rst: got %b expected 000", {gnt_mire, sdram_if.cyc, mire_if.ack}); else passes++;
        chk("rm_beat_lost", 32'(m_acks - saved), 32'd0);
        step();
        checks++; if (gnt_mire !== 1'b1 || sdram_if.adr !== 32'h508) $display("FAIL rm_regrant: gnt=%b adr=%h expected 1/00000508", gnt_mire, sdram_if.adr); else passes++;
    endtask

    initial begin
        test_reset();
        test_lone_mire();
        test_tie();
        test_vga_quantum();
        test_mire_preempt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
